rf_wb_sched: RTL and testbench
==============================

Name: rf_wb_sched

Overview:
- Write-back scheduler for the 8x16 register file's single write port.
- Arbitrates between ALU results and memory-load returns; buffers ALU results that lose arbitration in a small FIFO.
- Keeps a per-register busy scoreboard so decode can stall on read-after-write hazards.
- Sits between execute/memory stages and the register file write inputs: result, result_w, and the write enable.

Parameters:
- DEPTH, 2, ALU skid FIFO entries (power of two, >=2).
- NREG, 8, number of architectural registers.
- AW, 3, register address width, equal to log2(NREG).
- DW, 16, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  scheduler can accept ALU result.
- alu_dst  in  AW  ALU destination register.
- alu_data  in  DW  ALU result value.
- ld_valid  in  1  load data returning; cannot be back-pressured.
- ld_dst  in  AW  load destination register.
- ld_data  in  DW  load value.
- wr_en  out  1  register file write strobe.
- wr_addr  out  AW  register file write address.
- wr_data  out  DW  register file write data.
- iss_valid  in  1  instruction issued that will write a register.
- iss_dst  in  AW  its destination.
- rd_chk  in  1  check rd_addr for hazard.
- rd_addr  in  AW  decode read address A.
- rs_chk  in  1  check rs_addr for hazard.
- rs_addr  in  AW  decode read address B.
- hazard  out  1  a checked source is busy; decode must stall.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst=1 at a rising edge):
  - FIFO emptied; busy[NREG-1:0]=0.
  - wr_en=0, wr_addr=0, wr_data=0, err=0.
  - alu_ready is forced 0 while rst=1.
- ALU handshake:
  - alu_ready = !rst && (fifo count < DEPTH). It depends only on registered count; no combinational path from alu_valid.
  - Transfer occurs when alu_valid && alu_ready.
  - The ALU must hold dst/data stable while valid && !ready.
- Per-cycle selection, priority high to low:
  - (1) ld_valid: write the load.
  - (2) FIFO non-empty: write FIFO head and pop.
  - (3) FIFO empty and ALU transfer: bypass, write ALU directly without enqueue.
  - (4) Otherwise: idle.
- Enqueue rule: an ALU transfer not used in (3) is pushed into the FIFO tail. Push and pop in the same cycle leave the count unchanged.
- Write-port timing:
  - The selected source is registered into wr_en/wr_addr/wr_data: latency 1 cycle from selection to the strobe.
  - wr_en=0 when idle; wr_addr/wr_data hold their last values when idle.
- Ordering:
  - ALU results are written in acceptance order.
  - Load versus ALU ordering is by arrival at the scheduler.
- Scoreboard:
  - iss_valid sets busy[iss_dst] at the edge.
  - At an edge where wr_en=1, busy[wr_addr] is cleared; this is the same edge the register file captures the data.
  - Set and clear of the same index in the same cycle: set wins.
- Hazard:
  - hazard = (rd_chk && busy[rd_addr]) || (rs_chk && busy[rs_addr]). Purely combinational from registered busy.
  - There is no forwarding: a read is safe the cycle after busy clears.
- err (sticky until reset) is set by any of:
  - iss_valid to a register already busy and not being cleared that edge.
  - ld_valid while FIFO full and alu_valid, i.e. the load starves the FIFO. This is informational only; no data is lost.
  - wr_en writing a non-busy register.
- Boundary conditions:
  - Continuous ld_valid starves the FIFO indefinitely. alu_ready falls once the FIFO is full; ALU data is never dropped.
  - FIFO pointers wrap modulo DEPTH.
  - Reset asserted mid-operation discards pending FIFO entries and busy bits; no write is issued on the cycle after reset.

Test Plan:
- Reset, then alu_valid=1, dst=3, data=0x1234, FIFO empty -> next cycle wr_en=1, wr_addr=3, wr_data=0x1234; alu_ready stays 1.
- Same cycle ld_valid (dst=1, 0xAAAA) and alu_valid (dst=2, 0x5555) -> cycle+1 writes r1=0xAAAA; cycle+2 writes r2=0x5555 from FIFO; count back to 0.
- Hold ld_valid 4 cycles with alu_valid continuous, DEPTH=2 -> alu_ready drops after 2 accepts. After ld stops, 2 ALU writes drain in order, then alu_ready=1; no data lost.
- iss_valid dst=5, then rd_chk=1, rd_addr=5 -> hazard=1 until the edge with wr_en=1, wr_addr=5; hazard=0 the following cycle.
- iss_valid dst=4 at the same edge wr_en clears r4 -> busy[4] remains 1; a second iss_valid dst=4 while busy -> err=1, sticky.
- Fill FIFO, assert rst one cycle -> wr_en=0, alu_ready=0 during reset, FIFO empty and busy=0 afterwards; no stale writes appear.

Source files
------------

// File: rtl/rf_wb_sched.sv
// Write-back scheduler for the register file's single write port.
// Loads win arbitration, ALU losers wait in a skid FIFO, and a busy scoreboard flags RAW hazards.
module rf_wb_sched #(
    parameter int DEPTH = 2,
    parameter int NREG  = 8,
    parameter int AW    = 3,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_dst,
    input  logic [DW-1:0] alu_data,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_dst,
    input  logic [DW-1:0] ld_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_dst,
    input  logic          rd_chk,
    input  logic [AW-1:0] rd_addr,
    input  logic          rs_chk,
    input  logic [AW-1:0] rs_addr,
    output logic          hazard,
    output logic          err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {SEL_IDLE, SEL_LD, SEL_FIFO, SEL_ALU} sel_e;

    typedef struct packed {
        logic [AW-1:0] dst;
        logic [DW-1:0] data;
    } wb_ent_t;

    wb_ent_t         mem_q [DEPTH];
    wb_ent_t         mem_d [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            err_q, err_d;

    sel_e sel;
    logic fifo_empty, fifo_full, alu_xfer, push, pop;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(DEPTH));
    // Ready depends only on registered occupancy, never on alu_valid.
    assign alu_ready  = !rst && !fifo_full;
    assign alu_xfer   = alu_valid && alu_ready;

    always_comb begin
        sel = SEL_IDLE;
        if (ld_valid)         sel = SEL_LD;
        else if (!fifo_empty) sel = SEL_FIFO;
        else if (alu_xfer)    sel = SEL_ALU;
    end

    assign pop  = (sel == SEL_FIFO);
    assign push = alu_xfer && (sel != SEL_ALU);

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            mem_d[wptr_q] = '{dst: alu_dst, data: alu_data};
            wptr_d        = wptr_q + PW'(1);
        end
        if (pop) rptr_d = rptr_q + PW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Write port is one cycle behind selection; address/data hold when idle.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (sel)
            SEL_LD: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ld_dst;
                wr_data_d = ld_data;
            end
            SEL_FIFO: begin
                wr_en_d   = 1'b1;
                wr_addr_d = mem_q[rptr_q].dst;
                wr_data_d = mem_q[rptr_q].data;
            end
            SEL_ALU: begin
                wr_en_d   = 1'b1;
                wr_addr_d = alu_dst;
                wr_data_d = alu_data;
            end
            default: ;
        endcase
    end

    // Clear on the edge the register file captures; a same-edge issue re-sets.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_q)   busy_d[wr_addr_q] = 1'b0;
        if (iss_valid) busy_d[iss_dst]   = 1'b1;
    end

    always_comb begin
        err_d = err_q;
        if (iss_valid && busy_q[iss_dst] && !(wr_en_q && wr_addr_q == iss_dst))
            err_d = 1'b1;
        if (ld_valid && fifo_full && alu_valid)
            err_d = 1'b1;
        if (wr_en_q && !busy_q[wr_addr_q])
            err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    // Storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign err     = err_q;
    assign hazard  = (rd_chk && busy_q[rd_addr]) || (rs_chk && busy_q[rs_addr]);

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed bench for rf_wb_sched: hand-computed expectations checked with immediate assertions.
module tb_rf_wb_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [2:0]  alu_dst;
    logic [15:0] alu_data;
    logic        ld_valid;
    logic [2:0]  ld_dst;
    logic [15:0] ld_data;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        iss_valid;
    logic [2:0]  iss_dst;
    logic        rd_chk, rs_chk;
    logic [2:0]  rd_addr, rs_addr;
    logic        hazard, err;

    int checks = 0;
    int errors = 0;

    rf_wb_sched #(.DEPTH(2), .NREG(8), .AW(3), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_dst(ld_dst), .ld_data(ld_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_dst(iss_dst),
        .rd_chk(rd_chk), .rd_addr(rd_addr), .rs_chk(rs_chk), .rs_addr(rs_addr),
        .hazard(hazard), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        #0;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic [2:0] a, input logic [15:0] d);
        chk({tag, ".wr_en"}, 32'(wr_en), 32'd1);
        chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(a));
        chk({tag, ".wr_data"}, 32'(wr_data), 32'(d));
    endtask

    task automatic issue(input logic [2:0] d);
        iss_valid = 1'b1; iss_dst = d;
        tick();
        iss_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 0; alu_dst = 0; alu_data = 0;
        ld_valid = 0; ld_dst = 0; ld_data = 0;
        iss_valid = 0; iss_dst = 0;
        rd_chk = 0; rd_addr = 0; rs_chk = 0; rs_addr = 0;

        // reset state
        tick(); tick();
        chk("rst.wr_en", 32'(wr_en), 32'd0);
        chk("rst.wr_addr", 32'(wr_addr), 32'd0);
        chk("rst.wr_data", 32'(wr_data), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.alu_ready", 32'(alu_ready), 32'd0);
        rst = 1'b0; #1;
        chk("post_rst.alu_ready", 32'(alu_ready), 32'd1);

        // bypass: empty FIFO, ALU straight to the write port
        issue(3'd3);
        alu_valid = 1; alu_dst = 3'd3; alu_data = 16'h1234;
        tick();
        alu_valid = 0;
        chk_wr("bypass", 3'd3, 16'h1234);
        chk("bypass.alu_ready", 32'(alu_ready), 32'd1);
        tick();
        chk("bypass.idle_en", 32'(wr_en), 32'd0);
        chk("bypass.hold_data", 32'(wr_data), 32'h1234);
        chk("bypass.err", 32'(err), 32'd0);

        // load beats ALU; ALU result follows from FIFO
        issue(3'd1);
        issue(3'd2);
        ld_valid = 1; ld_dst = 3'd1; ld_data = 16'hAAAA;
        alu_valid = 1; alu_dst = 3'd2; alu_data = 16'h5555;
        tick();
        ld_valid = 0; alu_valid = 0;
        chk_wr("ld_first", 3'd1, 16'hAAAA);
        chk("ld_first.alu_ready", 32'(alu_ready), 32'd1);
        tick();
        chk_wr("fifo_pop", 3'd2, 16'h5555);
        tick();
        chk("drain.idle_en", 32'(wr_en), 32'd0);
        chk("drain.err", 32'(err), 32'd0);

        // hazard on r5 until its write lands
        issue(3'd5);
        rd_chk = 1; rd_addr = 3'd5; #1;
        chk("haz.rd_busy", 32'(hazard), 32'd1);
        rd_chk = 0; rs_chk = 1; rs_addr = 3'd5; #1;
        chk("haz.rs_busy", 32'(hazard), 32'd1);
        rs_addr = 3'd4; #1;
        chk("haz.rs_free", 32'(hazard), 32'd0);
        rs_chk = 0; rd_chk = 1;
        alu_valid = 1; alu_dst = 3'd5; alu_data = 16'h0055;
        tick();
        alu_valid = 0;
        chk_wr("haz.wr", 3'd5, 16'h0055);
        chk("haz.still_busy", 32'(hazard), 32'd1);
        tick();
        chk("haz.cleared", 32'(hazard), 32'd0);

        // same-edge set beats clear; then double issue is an error
        issue(3'd4);
        alu_valid = 1; alu_dst = 3'd4; alu_data = 16'h4444;
        tick();
        alu_valid = 0;
        chk_wr("setclr.wr", 3'd4, 16'h4444);
        issue(3'd4);
        rd_addr = 3'd4; #1;
        chk("setclr.busy", 32'(hazard), 32'd1);
        chk("setclr.no_err", 32'(err), 32'd0);
        issue(3'd4);
        chk("dbl_iss.err", 32'(err), 32'd1);
        tick();
        chk("dbl_iss.sticky", 32'(err), 32'd1);
        rst = 1; tick(); rst = 0; #1;
        chk("err_rst.err", 32'(err), 32'd0);
        chk("err_rst.busy", 32'(hazard), 32'd0);
        rd_chk = 0;

        // continuous loads starve the FIFO; ALU data must survive
        ld_valid = 1; ld_dst = 3'd0; ld_data = 16'h1000;
        alu_valid = 1; alu_dst = 3'd6; alu_data = 16'h0A06;
        tick();
        chk_wr("starve.L0", 3'd0, 16'h1000);
        chk("starve.rdy0", 32'(alu_ready), 32'd1);
        ld_data = 16'h1001; alu_dst = 3'd7; alu_data = 16'h0A07;
        tick();
        chk_wr("starve.L1", 3'd0, 16'h1001);
        chk("starve.rdy1", 32'(alu_ready), 32'd0);
        ld_data = 16'h1002; alu_dst = 3'd5; alu_data = 16'h0A05;
        tick();
        chk_wr("starve.L2", 3'd0, 16'h1002);
        chk("starve.err", 32'(err), 32'd1);
        ld_data = 16'h1003;
        tick();
        chk_wr("starve.L3", 3'd0, 16'h1003);
        chk("starve.rdy3", 32'(alu_ready), 32'd0);
        ld_valid = 0;
        tick();
        chk_wr("starve.D0", 3'd6, 16'h0A06);
        chk("starve.rdy4", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 0;
        chk_wr("starve.D1", 3'd7, 16'h0A07);
        tick();
        chk_wr("starve.D2", 3'd5, 16'h0A05);
        chk("starve.rdy6", 32'(alu_ready), 32'd1);
        tick();
        chk("starve.idle", 32'(wr_en), 32'd0);

        // reset mid-operation with a full FIFO
        rst = 1; tick(); rst = 0;
        issue(3'd1);
        ld_valid = 1; ld_dst = 3'd2; ld_data = 16'hBEEF;
        alu_valid = 1; alu_dst = 3'd1; alu_data = 16'hC001;
        tick();
        alu_data = 16'hC002;
        tick();
        ld_valid = 0; alu_valid = 0;
        chk("midrst.full", 32'(alu_ready), 32'd0);
        rst = 1; #1;
        chk("midrst.ready_low", 32'(alu_ready), 32'd0);
        tick();
        rst = 0;
        chk("midrst.wr_en", 32'(wr_en), 32'd0);
        tick();
        chk("midrst.no_stale", 32'(wr_en), 32'd0);
        chk("midrst.ready", 32'(alu_ready), 32'd1);
        rd_chk = 1; rd_addr = 3'd1; #1;
        chk("midrst.busy", 32'(hazard), 32'd0);
        tick();
        chk("midrst.no_stale2", 32'(wr_en), 32'd0);
        chk("midrst.err", 32'(err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
